uart_freq_loader: RTL
=====================

// Module: uart_freq_loader
// PURPOSE
//   Frame parser between UART_module_RX and the exponent NCO.
//   - Assembles 4-byte frames from received bytes into a 12-bit NCO tuning word.
//   - Drives the NCO freq input, replacing the constant tie-off.
//   - Rejects malformed or stalled frames and counts good frames for the seven-segment display.
// PARAMETERS
//   HEADER       8'hA5   frame start byte
//   FREQ_RESET   12'd14  freq value after reset
//   TIMEOUT_CYC  50000   max idle cycles between bytes inside a frame (1 ms @ 50 MHz); must be >= 2
// PORTS
//   clk         in   1   system clock, 50 MHz
//   reset_n     in   1   asynchronous reset, active-low
//   rx_byte     in   8   received byte, valid only while rx_valid=1
//   rx_valid    in   1   one-cycle strobe: rx_byte is new
//   freq        out  12  NCO tuning word
//   freq_upd    out  1   one-cycle pulse: freq just changed
//   frame_err   out  1   one-cycle pulse: frame rejected
//   good_cnt    out  8   count of accepted frames, wraps 255->0
// BEHAVIOUR
//   Frame format: HEADER, HI, LO, CHK.
//   - freq = {HI[3:0], LO}. HI[7:4] must be 0.
//   - CHK = HEADER ^ HI ^ LO.
//   Reset (async assert, sync deassert edge-insensitive):
//   - freq=FREQ_RESET; freq_upd=0; frame_err=0; good_cnt=0.
//   - state=IDLE; timer=0; hi/lo shadow regs = 0.
//   FSM states: IDLE -> GET_HI -> GET_LO -> GET_CHK -> IDLE. Transitions occur only on rx_valid.
//   - IDLE: rx_byte==HEADER -> GET_HI. Any other byte is ignored silently (no err).
//   - GET_HI: store byte. If byte[7:4]!=0 -> frame_err pulse, IDLE. Else -> GET_LO.
//   - GET_LO: store byte -> GET_CHK.
//   - GET_CHK: byte==HEADER^hi^lo -> commit. Else frame_err pulse, freq unchanged. Either way -> IDLE.
//   - HEADER received inside a frame is treated as data; no resync.
//   Commit:
//   - freq, freq_upd=1 and good_cnt+1 are registered on the edge that samples the valid CHK byte.
//   - Outputs are visible 1 cycle after the rx_valid cycle.
//   - freq_upd and frame_err are high for exactly 1 cycle, and are never both high.
//   Timeout:
//   - timer clears on every rx_valid, increments each cycle while state!=IDLE, and is held at 0 in IDLE.
//   - timer==TIMEOUT_CYC-1 with rx_valid=0 -> frame_err pulse, IDLE, partial frame discarded.
//   - rx_valid in that same cycle wins: the byte is processed normally and no timeout occurs.
//   Back-to-back rx_valid on consecutive cycles is legal. Each strobe consumes exactly one byte.
//   freq holds its value between commits. Rejected frames never disturb freq.
//   Reset mid-frame: partial frame discarded, freq returns to FREQ_RESET.
// CONFIGURATION
//   UART_FREQ_LOADER_ACK_EN
//   Defined: adds ports ack_byte (out, 8) and ack_send (out, 1), both reset to 0.
//   - ack_send is a one-cycle pulse coincident with freq_upd (ack_byte=8'h06) or frame_err (ack_byte=8'h15).
//   - ack_byte holds its value until the next ack. Ports connect to UART_module_TX send_byte/send_en.
//   Undefined: the ack ports and their logic are absent. Core behaviour is identical.
// TESTING
//   1. Reset release, no rx -> freq=14, good_cnt=0, no pulses for 100k cycles.
//   2. Send A5,01,23,87 -> freq=12'h123 and freq_upd=1 one cycle after the CHK strobe; good_cnt=1.
//   3. Send A5,01,23,88 -> frame_err pulse, freq stays 12'h123, good_cnt unchanged.
//   4. Send A5,10 -> immediate frame_err. Then A5,00,0E,AB -> freq=14, good_cnt+1.
//   5. Send A5,02 then idle TIMEOUT_CYC cycles -> frame_err at cycle TIMEOUT_CYC-1 after the 02 strobe.
//      Repeat with the next byte landing exactly on that cycle -> no err, frame continues.
//   6. 256 good frames back-to-back (consecutive-cycle strobes) -> good_cnt wraps to 0.
//      Reset asserted mid-frame -> freq=14 asynchronously.
//      With ACK_EN defined: ack_send/ack_byte=06 for good frames, 15 for bad, matching tests 2-5.

Source files
------------

// File: rtl/uart_freq_loader.sv
// ---------------------------------------------------------------------------
// uart_freq_loader
//   Frame parser between the UART receiver and the exponent NCO. It assembles
//   4-byte frames (HEADER, HI, LO, CHK) into a 12-bit tuning word
//   freq = {HI[3:0], LO} and commits the word only when:
//     - HI[7:4] == 0, and
//     - CHK == HEADER ^ HI ^ LO.
//   Malformed frames and frames that stall between bytes are rejected.
//   Accepted frames are counted for the seven-segment display.
//
// Optional feature (macro UART_FREQ_LOADER_ACK_EN):
//   Adds an ACK/NAK byte stream for the UART transmitter.
//
// Ports
//   clk        in   1   system clock (50 MHz)
//   reset_n    in   1   asynchronous reset, active-low
//   rx_byte    in   8   received byte, valid while rx_valid=1
//   rx_valid   in   1   one-cycle strobe: rx_byte is new
//   freq       out  12  NCO tuning word
//   freq_upd   out  1   one-cycle pulse: freq just committed
//   frame_err  out  1   one-cycle pulse: frame rejected
//   good_cnt   out  8   accepted-frame count, wraps 255->0
//   ack_byte   out  8   (ACK_EN only) 8'h06 ACK / 8'h15 NAK, held between acks
//   ack_send   out  1   (ACK_EN only) one-cycle strobe with freq_upd/frame_err
// ---------------------------------------------------------------------------
module uart_freq_loader #(
  parameter logic [7:0]  HEADER      = 8'hA5,
  parameter logic [11:0] FREQ_RESET  = 12'd14,
  parameter int          TIMEOUT_CYC = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_byte,
  input  logic        rx_valid,
  output logic [11:0] freq,
  output logic        freq_upd,
  output logic        frame_err,
`ifdef UART_FREQ_LOADER_ACK_EN
  output logic [7:0]  ack_byte,
  output logic        ack_send,
`endif
  output logic [7:0]  good_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE, GET_HI, GET_LO, GET_CHK} state_t;

  state_t        state, next_state;
  logic [TW-1:0] timer;
  logic [7:0]    hi_q, lo_q;
  logic          commit, reject;

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) assignments, so all
  // registers sample the pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Next-state and commit/reject decode. A byte arriving in the cycle where
  // the timer expires takes priority over the timeout.
  // NOTE: every output of this block is given a default first, so no path can
  // leave a value unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    commit     = 1'b0;
    reject     = 1'b0;
    if (rx_valid) begin
      unique case (state)
        IDLE:    if (rx_byte == HEADER) next_state = GET_HI;
        GET_HI:  begin
          if (rx_byte[7:4] != 4'd0) begin
            reject     = 1'b1;
            next_state = IDLE;
          end else begin
            next_state = GET_LO;
          end
        end
        GET_LO:  next_state = GET_CHK;
        GET_CHK: begin
          next_state = IDLE;
          if (rx_byte == (HEADER ^ hi_q ^ lo_q)) commit = 1'b1;
          else                                   reject = 1'b1;
        end
        default: next_state = IDLE;
      endcase
    end else if (state != IDLE && timer == TIMER_LAST) begin
      reject     = 1'b1;
      next_state = IDLE;
    end
  end

  // Inter-byte watchdog: cleared by every strobe and whenever the frame is
  // (or is about to be) idle, so it only counts silence inside a frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                            timer <= '0;
    else if (rx_valid || next_state == IDLE) timer <= '0;
    else                                     timer <= timer + 1'b1;
  end

  // Payload shadow registers and committed outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi_q      <= 8'd0;
      lo_q      <= 8'd0;
      freq      <= FREQ_RESET;
      freq_upd  <= 1'b0;
      frame_err <= 1'b0;
      good_cnt  <= 8'd0;
    end else begin
      if (rx_valid && state == GET_HI) hi_q <= rx_byte;
      if (rx_valid && state == GET_LO) lo_q <= rx_byte;
      freq_upd  <= commit;
      frame_err <= reject;
      if (commit) begin
        freq     <= {hi_q[3:0], lo_q};
        good_cnt <= good_cnt + 8'd1;
      end
    end
  end

`ifdef UART_FREQ_LOADER_ACK_EN
  // ACK/NAK towards the transmitter, aligned with freq_upd/frame_err.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_byte <= 8'd0;
      ack_send <= 1'b0;
    end else begin
      ack_send <= commit | reject;
      if (commit)      ack_byte <= 8'h06;
      else if (reject) ack_byte <= 8'h15;
    end
  end
`endif

endmodule
